// File: rtl/lcd_time_writer.sv
// HD44780-class 8-bit write-only LCD driver: power-up/init, then refreshes line 1 cols 0..10 from a per-frame snapshot of num_data.
// Optional build macro LCD_WRITER_SKIP_UNCHANGED_EN: only rewrite a frame when num_data differs from the last written snapshot.
module lcd_time_writer #(
   parameter int POWERUP_CYC    = 750000,
   parameter int E_PULSE_CYC    = 25,
   parameter int CMD_WAIT_CYC   = 2500,
   parameter int CLEAR_WAIT_CYC = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [43:0] num_data,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_e,
   output logic [7:0]  lcd_db,
   output logic        init_done,
   output logic        frame_done
);

   localparam int MAX_CYC_A = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
   localparam int MAX_CYC_B = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
   localparam int MAX_CYC   = (MAX_CYC_A > MAX_CYC_B) ? MAX_CYC_A : MAX_CYC_B;
   localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   // Counters are loaded with (length - 1) and the phase ends on the cycle they read zero.
   localparam logic [CNT_W-1:0] PWR_LOAD   = CNT_W'((POWERUP_CYC    > 0) ? POWERUP_CYC    - 1 : 0);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'((E_PULSE_CYC    > 0) ? E_PULSE_CYC    - 1 : 0);
   localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'((CMD_WAIT_CYC   > 0) ? CMD_WAIT_CYC   - 1 : 0);
   localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'((CLEAR_WAIT_CYC > 0) ? CLEAR_WAIT_CYC - 1 : 0);

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_SETUP,
      ST_PULSE,
      ST_WAIT,
      ST_FRAME
   } state_t;

   typedef enum logic [1:0] {
      PH_INIT,
      PH_ADDR,
      PH_DATA
   } phase_t;

   state_t           state;
   state_t           state_next;
   phase_t           phase;
   phase_t           phase_next;
   logic [3:0]       idx;
   logic [3:0]       idx_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [43:0]      snapshot;
   logic [43:0]      snapshot_next;
   logic             frame_go;
   logic [3:0]       nib;
   logic [7:0]       xfer_byte;
   logic             xfer_rs;

   function automatic logic [7:0] char_of(input logic [3:0] n);
      if (n <= 4'd9) begin
         return 8'h30 + {4'h0, n};
      end else if (n == 4'd10) begin
         return 8'h3A;
      end else begin
         return 8'h20;
      end
   endfunction

   // In FRAME, phase still tells what preceded it: PH_INIT means the first frame after init.
`ifdef LCD_WRITER_SKIP_UNCHANGED_EN
   assign frame_go = (phase != PH_DATA) || (num_data != snapshot);
`else
   assign frame_go = 1'b1;
`endif

   always_comb begin
      state_next    = state;
      phase_next    = phase;
      idx_next      = idx;
      cnt_next      = cnt;
      snapshot_next = snapshot;
      case (state)
         ST_POWERUP: begin
            if (cnt == '0) begin
               state_next = ST_SETUP;
               phase_next = PH_INIT;
               idx_next   = 4'd0;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         ST_SETUP: begin
            state_next = ST_PULSE;
            cnt_next   = PULSE_LOAD;
         end
         ST_PULSE: begin
            if (cnt == '0) begin
               state_next = ST_WAIT;
               cnt_next   = (lcd_db == 8'h01) ? CLR_LOAD : CMD_LOAD;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (cnt != '0) begin
               cnt_next = cnt - CNT_W'(1);
            end else begin
               case (phase)
                  PH_INIT: begin
                     if (idx == 4'd3) begin
                        state_next = ST_FRAME;
                     end else begin
                        state_next = ST_SETUP;
                        idx_next   = idx + 4'd1;
                     end
                  end
                  PH_ADDR: begin
                     state_next = ST_SETUP;
                     phase_next = PH_DATA;
                     idx_next   = 4'd0;
                  end
                  default: begin
                     if (idx == 4'd10) begin
                        state_next = ST_FRAME;
                     end else begin
                        state_next = ST_SETUP;
                        idx_next   = idx + 4'd1;
                     end
                  end
               endcase
            end
         end
         ST_FRAME: begin
            snapshot_next = num_data;
            if (frame_go) begin
               state_next = ST_SETUP;
               phase_next = PH_ADDR;
               idx_next   = 4'd0;
            end
         end
         default: begin
            state_next = ST_POWERUP;
            cnt_next   = PWR_LOAD;
         end
      endcase
   end

   // Byte for the transfer about to start; data bytes read the frozen snapshot.
   always_comb begin
      nib = 4'h0;
      for (int k = 0; k < 11; k++) begin
         if (idx_next == 4'(k)) begin
            nib = snapshot[4*k +: 4];
         end
      end
      case (phase_next)
         PH_INIT: begin
            case (idx_next)
               4'd0:    xfer_byte = 8'h38;
               4'd1:    xfer_byte = 8'h0C;
               4'd2:    xfer_byte = 8'h06;
               default: xfer_byte = 8'h01;
            endcase
         end
         PH_ADDR: xfer_byte = 8'h80;
         default: xfer_byte = char_of(nib);
      endcase
      xfer_rs = (phase_next == PH_DATA);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_POWERUP;
         phase    <= PH_INIT;
         idx      <= 4'd0;
         cnt      <= PWR_LOAD;
         snapshot <= '0;
      end else begin
         state    <= state_next;
         phase    <= phase_next;
         idx      <= idx_next;
         cnt      <= cnt_next;
         snapshot <= snapshot_next;
      end
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         lcd_rs     <= 1'b0;
         lcd_db     <= 8'h00;
         lcd_e      <= 1'b0;
         init_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (state_next == ST_SETUP) begin
            lcd_rs <= xfer_rs;
            lcd_db <= xfer_byte;
         end
         lcd_e      <= (state_next == ST_PULSE);
         init_done  <= init_done | (state_next == ST_FRAME);
         frame_done <= (state_next == ST_FRAME) && (state != ST_FRAME) && (phase == PH_DATA);
      end
   end

   assign lcd_rw = 1'b0;

endmodule
